// File: rtl/chunk_conditional_subtract.sv
// Chunked conditional subtract: emits X-N when X>=N, else X, LS chunk first.
// Optional CSUB_REDUCE_COUNT_EN adds reduce_count_out, a count of reduced operands.
module chunk_conditional_subtract #(
  parameter int BITS_IN_NUM   = 4096,
  parameter int REGISTER_SIZE = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [REGISTER_SIZE-1:0] data_in,
  input  logic                     data_valid_in,
  input  logic [REGISTER_SIZE-1:0] modulus_in,
  output logic                     data_consumed_out,
  output logic [REGISTER_SIZE-1:0] data_out,
  output logic                     data_valid_out,
  input  logic                     data_ready_in,
  output logic                     reduced_out
`ifdef CSUB_REDUCE_COUNT_EN
  ,
  output logic [15:0]              reduce_count_out
`endif
);

  localparam int NUM_BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BLOCKS - 1);

  typedef enum logic {LOAD, EMIT} state_t;

  state_t state;
  state_t state_nxt;

  logic [REGISTER_SIZE-1:0] raw_mem  [NUM_BLOCKS];
  logic [REGISTER_SIZE-1:0] diff_mem [NUM_BLOCKS];

  logic [IDX_W-1:0] load_idx;
  logic [IDX_W-1:0] emit_idx;
  logic             borrow;
  logic             sel;

  logic             take;
  logic             give;
  logic             load_last;
  logic             emit_last;
  logic [REGISTER_SIZE:0] sub;

  // Extra top bit of the wide subtraction is the borrow-out.
  assign sub = {1'b0, data_in}
             - {1'b0, modulus_in}
             - {{REGISTER_SIZE{1'b0}}, borrow};

  assign take      = (state == LOAD) && data_valid_in;
  assign give      = (state == EMIT) && data_ready_in;
  assign load_last = (load_idx == LAST);
  assign emit_last = (emit_idx == LAST);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= LOAD;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (take && load_last) state_nxt = EMIT;
      EMIT:    if (give && emit_last) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    data_consumed_out = 1'b0;
    data_valid_out    = 1'b0;
    reduced_out       = 1'b0;
    data_out          = '0;
    unique case (1'b1)
      (state == LOAD): begin
        data_consumed_out = data_valid_in;
      end
      (state == EMIT): begin
        data_valid_out = 1'b1;
        reduced_out    = sel;
        data_out       = sel ? diff_mem[emit_idx]
                             : raw_mem[emit_idx];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      load_idx <= '0;
      borrow   <= 1'b0;
      sel      <= 1'b0;
    end else if (take) begin
      if (load_last) begin
        load_idx <= '0;
        borrow   <= 1'b0;
        sel      <= ~sub[REGISTER_SIZE];
      end else begin
        load_idx <= load_idx + 1'b1;
        borrow   <= sub[REGISTER_SIZE];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)     emit_idx <= '0;
    else if (give) begin
      if (emit_last)   emit_idx <= '0;
      else             emit_idx <= emit_idx + 1'b1;
    end
  end

  // Storage arrays carry no reset; contents are only read after a full load.
  always_ff @(posedge clk_in) begin
    if (take) begin
      raw_mem[load_idx]  <= data_in;
      diff_mem[load_idx] <= sub[REGISTER_SIZE-1:0];
    end
  end

`ifdef CSUB_REDUCE_COUNT_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      reduce_count_out <= '0;
    else if (give && emit_last && sel)
      reduce_count_out <= reduce_count_out + 16'd1;
  end
`endif

endmodule

// File: tb/tb_chunk_conditional_subtract.sv
// Scoreboard bench for chunk_conditional_subtract at 128/32.
// Directed steps; monitor pops expected chunks on each output handshake.
module tb_chunk_conditional_subtract;

  localparam int RS = 32;
  localparam int NB = 4;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic [RS-1:0] data_in = '0;
  logic          data_valid_in = 1'b0;
  logic [RS-1:0] modulus_in = '0;
  logic          data_consumed_out;
  logic [RS-1:0] data_out;
  logic          data_valid_out;
  logic          data_ready_in = 1'b1;
  logic          reduced_out;
`ifdef CSUB_REDUCE_COUNT_EN
  logic [15:0]   reduce_count_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [RS:0] exp_q [$];

  chunk_conditional_subtract #(
    .BITS_IN_NUM  (128),
    .REGISTER_SIZE(RS)
  ) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .data_in          (data_in),
    .data_valid_in    (data_valid_in),
    .modulus_in       (modulus_in),
    .data_consumed_out(data_consumed_out),
    .data_out         (data_out),
    .data_valid_out   (data_valid_out),
    .data_ready_in    (data_ready_in),
    .reduced_out      (reduced_out)
`ifdef CSUB_REDUCE_COUNT_EN
    ,
    .reduce_count_out (reduce_count_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (rst_n_in && data_valid_out) begin
      check("no_consume_in_emit", 128'(data_consumed_out), 128'd0);
      if (data_ready_in) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 128'(data_out), 128'hx);
        end else begin
          logic [RS:0] e;
          e = exp_q.pop_front();
          check("data_out", 128'(data_out), 128'(e[RS-1:0]));
          check("reduced_out", 128'(reduced_out), 128'(e[RS]));
        end
      end
    end
  end

  task automatic send(input logic [127:0] x,
                      input logic [127:0] n,
                      input int nch,
                      input bit push);
    logic [127:0] r;
    logic red;
    red = (x >= n);
    r = red ? x - n : x;
    if (push)
      for (int i = 0; i < NB; i++)
        exp_q.push_back({red, r[i*RS +: RS]});
    for (int i = 0; i < nch; i++) begin
      bit got;
      got = 1'b0;
      data_in = x[i*RS +: RS];
      modulus_in = n[i*RS +: RS];
      data_valid_in = 1'b1;
      for (int c = 0; c < 50 && !got; c++) begin
        @(negedge clk_in);
        if (data_consumed_out) got = 1'b1;
        @(posedge clk_in);
        #1;
      end
      if (!got) check("consume_timeout", 128'd0, 128'd1);
      if (i == NB - 1)
        check("first_valid_latency", 128'(data_valid_out), 128'd1);
    end
    data_valid_in = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 100 && (exp_q.size() != 0 || data_valid_out); c++) begin
      @(posedge clk_in);
      #1;
    end
    check("drain_queue_empty", 128'(exp_q.size()), 128'd0);
    check("drain_valid_low", 128'(data_valid_out), 128'd0);
  endtask

  initial begin
    #2;
    check("rst_valid", 128'(data_valid_out), 128'd0);
    check("rst_data", 128'(data_out), 128'd0);
    check("rst_reduced", 128'(reduced_out), 128'd0);
    check("rst_consumed", 128'(data_consumed_out), 128'd0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;

    send(128'd100, 128'd7, NB, 1'b1);
    drain();

    send(128'd5, 128'd7, NB, 1'b1);
    drain();

    send(128'hFFFFFFFF_00000000_12345678_00000001,
         128'hFFFFFFFF_00000000_12345678_00000001, NB, 1'b1);
    drain();

    send(128'h1 << 96, 128'd1, NB, 1'b1);
    drain();

    // Backpressure at emit chunk 1 with the next operand already offered.
    send(128'd100, 128'd7, NB, 1'b1);
    @(posedge clk_in);
    #1;
    data_ready_in = 1'b0;
    data_in = 32'd5;
    modulus_in = 32'd7;
    data_valid_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in);
      check("bp_data", 128'(data_out), 128'd0);
      check("bp_valid", 128'(data_valid_out), 128'd1);
      check("bp_reduced", 128'(reduced_out), 128'd1);
      @(posedge clk_in);
      #1;
    end
    data_ready_in = 1'b1;
    send(128'd5, 128'd7, NB, 1'b1);
    drain();

    send(128'd100, 128'd7, 2, 1'b0);
    rst_n_in = 1'b0;
    #1;
    check("midrst_valid", 128'(data_valid_out), 128'd0);
    check("midrst_data", 128'(data_out), 128'd0);
    check("midrst_reduced", 128'(reduced_out), 128'd0);
    check("midrst_consumed", 128'(data_consumed_out), 128'd0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    send(128'd9, 128'd7, NB, 1'b1);
    drain();

`ifdef CSUB_REDUCE_COUNT_EN
    check("reduce_count", 128'(reduce_count_out), 128'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
